// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Turns symbolic instructions (control-op code plus operand fields) into
//   32-bit MIPS words and streams them into instruction memory through its
//   write port. A load session is opened with Start, accepts exactly Length
//   instructions, then drains the final write and pulses Done.
//
// Ports
//   Clk, Rst_n            clock (rising edge) / asynchronous active-low reset
//   Start                 open a session (only acted on while idle)
//   BaseAddr, Length      first IMem word address / instructions to accept
//   InValid, InReady      instruction handshake (see below)
//   OpSel                 control-op code, 0 = nop, 1..53 legal, 54..63 illegal
//   Rs, Rt, Rd, Shamt     register / shift-amount fields
//   Imm16, Target26       immediate / jump-target fields
//   IMemWrite/Addr/Data   registered IMem write port
//   Busy, Done, Error     session status (Error sticky until next Start)
//   DbgState              current FSM state for observation
//
// Handshake: an instruction is consumed on a rising edge where InValid and
//   InReady are both 1. InReady is 1 only while loading and does not depend on
//   InValid. The encoded word appears on the write port the cycle after the
//   accept; IMemAddr/IMemData hold their last values when no write is issued.
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [LEN_W-1:0]  Length,
  input  logic              InValid,
  output logic              InReady,
  input  logic [5:0]        OpSel,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Shamt,
  input  logic [15:0]       Imm16,
  input  logic [25:0]       Target26,
  output logic              IMemWrite,
  output logic [ADDR_W-1:0] IMemAddr,
  output logic [31:0]       IMemData,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                accept;

  // Encoder: start from the raw operand fields, then let each op override
  // the fields its encoding fixes. Shamt is only passed through for the
  // immediate shifts; everywhere else it is 0 or a fixed constant.
  logic [5:0]  e_op, e_fn;
  logic [4:0]  e_rs, e_rt, e_rd, e_sh;
  logic [1:0]  e_fmt;
  logic        enc_legal;
  logic [31:0] enc_word;

  always_comb begin
    e_op      = 6'd0;
    e_fn      = 6'd0;
    e_rs      = Rs;
    e_rt      = Rt;
    e_rd      = Rd;
    e_sh      = 5'd0;
    e_fmt     = FMT_R;
    enc_legal = 1'b1;
    case (OpSel)
      6'd0:  begin e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0; end
      6'd1:  begin e_rs = 5'd0; e_sh = Shamt; end
      6'd3:  begin e_rs = 5'd1; e_sh = Shamt; e_fn = 6'd2; end
      6'd4:  begin e_rs = 5'd0; e_sh = Shamt; e_fn = 6'd2; end
      6'd6:  begin e_rs = 5'd0; e_sh = Shamt; e_fn = 6'd3; end
      6'd7:  e_fn = 6'd4;
      6'd9:  begin e_sh = 5'd1; e_fn = 6'd6; end
      6'd10: e_fn = 6'd6;
      6'd11: e_fn = 6'd7;
      6'd12: begin e_rt = 5'd0; e_rd = 5'd0; e_fn = 6'd8; end
      6'd13: e_fn = 6'd10;
      6'd14: e_fn = 6'd11;
      6'd15: begin e_rs = 5'd0; e_rt = 5'd0; e_fn = 6'd16; end
      6'd16: begin e_rt = 5'd0; e_rd = 5'd0; e_fn = 6'd17; end
      6'd17: begin e_rs = 5'd0; e_rt = 5'd0; e_fn = 6'd18; end
      6'd18: begin e_rt = 5'd0; e_rd = 5'd0; e_fn = 6'd19; end
      6'd19: begin e_rd = 5'd0; e_fn = 6'd24; end
      6'd20: begin e_rd = 5'd0; e_fn = 6'd25; end
      6'd21: e_fn = 6'd32;
      6'd24: e_fn = 6'd33;
      6'd25: e_fn = 6'd34;
      6'd26: e_fn = 6'd36;
      6'd27: e_fn = 6'd37;
      6'd28: e_fn = 6'd38;
      6'd29: e_fn = 6'd39;
      6'd30: e_fn = 6'd42;
      6'd31: e_fn = 6'd43;
      // SPECIAL2 group
      6'd2:  begin e_op = 6'd28; e_rd = 5'd0; e_fn = 6'd0; end
      6'd5:  begin e_op = 6'd28; e_fn = 6'd2; end
      6'd8:  begin e_op = 6'd28; e_rd = 5'd0; e_fn = 6'd4; end
      // SPECIAL3 BSHFL: sub-op lives in the shamt field
      6'd22: begin e_op = 6'd31; e_rs = 5'd0; e_sh = 5'd16; e_fn = 6'd32; end
      6'd23: begin e_op = 6'd31; e_rs = 5'd0; e_sh = 5'd24; e_fn = 6'd32; end
      // I-format
      6'd53: begin e_fmt = FMT_I; e_op = 6'd8;  end
      6'd32: begin e_fmt = FMT_I; e_op = 6'd9;  end
      6'd33: begin e_fmt = FMT_I; e_op = 6'd10; end
      6'd34: begin e_fmt = FMT_I; e_op = 6'd11; end
      6'd35: begin e_fmt = FMT_I; e_op = 6'd12; end
      6'd36: begin e_fmt = FMT_I; e_op = 6'd13; end
      6'd37: begin e_fmt = FMT_I; e_op = 6'd14; end
      6'd38: begin e_fmt = FMT_I; e_op = 6'd15; e_rs = 5'd0; end
      6'd49: begin e_fmt = FMT_I; e_op = 6'd4;  end
      6'd50: begin e_fmt = FMT_I; e_op = 6'd5;  end
      6'd51: begin e_fmt = FMT_I; e_op = 6'd6;  e_rt = 5'd0; end
      6'd52: begin e_fmt = FMT_I; e_op = 6'd7;  e_rt = 5'd0; end
      // REGIMM: branch condition selected by the rt field
      6'd47: begin e_fmt = FMT_I; e_op = 6'd1;  e_rt = 5'd1; end
      6'd48: begin e_fmt = FMT_I; e_op = 6'd1;  e_rt = 5'd0; end
      6'd41: begin e_fmt = FMT_I; e_op = 6'd32; end
      6'd42: begin e_fmt = FMT_I; e_op = 6'd33; end
      6'd43: begin e_fmt = FMT_I; e_op = 6'd35; end
      6'd44: begin e_fmt = FMT_I; e_op = 6'd40; end
      6'd45: begin e_fmt = FMT_I; e_op = 6'd41; end
      6'd46: begin e_fmt = FMT_I; e_op = 6'd43; end
      // J-format
      6'd39: begin e_fmt = FMT_J; e_op = 6'd2; end
      6'd40: begin e_fmt = FMT_J; e_op = 6'd3; end
      default: enc_legal = 1'b0;
    endcase

    case (e_fmt)
      FMT_I:   enc_word = {e_op, e_rs, e_rt, Imm16};
      FMT_J:   enc_word = {e_op, Target26};
      default: enc_word = {e_op, e_rs, e_rt, e_rd, e_sh, e_fn};
    endcase
  end

  // Session control
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    InReady = (state_q == ST_LOAD);
    accept  = InValid & InReady;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          ptr_d   = BaseAddr;
          rem_d   = Length;
          err_d   = 1'b0;
          state_d = (Length == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          // Illegal ops still use up a slot, but leave memory and the
          // address pointer untouched.
          if (enc_legal) begin
            wr_d   = 1'b1;
            addr_d = ptr_q;
            data_d = enc_word;
            ptr_d  = ptr_q + ADDR_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign IMemWrite = wr_q;
  assign IMemAddr  = addr_q;
  assign IMemData  = data_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Error     = err_q;
  assign DbgState  = state_q;

endmodule
